// File: rtl/game_pkg.sv
// Shared game constants (choice encoding, countdown state code) and the RNG handshake state type.
package game_pkg;

  localparam logic [1:0] ROCK      = 2'd0;
  localparam logic [1:0] PAPER     = 2'd1;
  localparam logic [1:0] SCISSORS  = 2'd2;

  localparam logic [1:0] COUNTDOWN = 2'b01;

  typedef enum logic {IDLE, DRAW} rng_state_t;

endpackage

// File: rtl/random_choice_gen_lfsr.sv
// Galois LFSR with synchronous reseed and all-zero lock-up guard; one-cycle update, no backpressure.
module lfsr_galois #(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = 16'hB400,
  parameter logic [W-1:0] SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= SEED;
    end else if (load) begin
      q <= (load_val == '0) ? SEED : load_val;
    end else if (q == '0) begin
      q <= SEED;
    end else begin
      q <= (q >> 1) ^ (q[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/random_choice_gen.sv
// Opponent-choice generator: LFSR rejection sampling, bounded retries, then mod-N counter fallback.
// draw_valid 2..2+MAX_RETRY cycles after draw_req; requests while busy are dropped. Option macro: RANDOM_SEED_LOAD_EN.
module random_choice_gen
  import game_pkg::*;
#(
  parameter int                LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED        = 16'hACE1,
  parameter int                CHOICE_W    = 2,
  parameter int                NUM_CHOICES = 3,
  parameter int                MAX_RETRY   = 3
) (
  input  logic                clk,
  input  logic                rst,
`ifdef RANDOM_SEED_LOAD_EN
  input  logic                seed_load,
  input  logic [LFSR_W-1:0]   seed_in,
`endif
  input  logic                draw_req,
  output logic                busy,
  output logic                draw_valid,
  output logic [CHOICE_W-1:0] com_result,
  output logic                fallback
);

  localparam logic [CHOICE_W:0]   NUM_C     = (CHOICE_W + 1)'(NUM_CHOICES);
  localparam logic [CHOICE_W-1:0] CNT_MAX   = CHOICE_W'(NUM_CHOICES - 1);
  localparam logic [3:0]          RETRY_MAX = 4'(MAX_RETRY);

  logic [LFSR_W-1:0] lfsr;
  logic              load;
  logic [LFSR_W-1:0] load_val;

`ifdef RANDOM_SEED_LOAD_EN
  assign load     = seed_load;
  assign load_val = seed_in;
`else
  assign load     = 1'b0;
  assign load_val = '0;
`endif

  lfsr_galois #(
    .W    (LFSR_W),
    .TAPS (LFSR_TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .q        (lfsr)
  );

  // Upper LFSR bits only feed the shift chain; they never reach the sample.
  logic lfsr_unused;
  assign lfsr_unused = ^lfsr[LFSR_W-1:CHOICE_W];

  logic [CHOICE_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CHOICE_W'(1);
    end
  end

  logic [CHOICE_W-1:0] sample;
  logic                accept;

  assign sample = lfsr[CHOICE_W-1:0];
  assign accept = ({1'b0, sample} < NUM_C);

  rng_state_t          state, state_nxt;
  logic [3:0]          retry, retry_nxt;
  logic                valid_nxt, fallback_nxt;
  logic [CHOICE_W-1:0] result_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      retry      <= '0;
      draw_valid <= 1'b0;
      com_result <= '0;
      fallback   <= 1'b0;
    end else begin
      state      <= state_nxt;
      retry      <= retry_nxt;
      draw_valid <= valid_nxt;
      com_result <= result_nxt;
      fallback   <= fallback_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    retry_nxt    = retry;
    valid_nxt    = 1'b0;
    result_nxt   = com_result;
    fallback_nxt = fallback;
    case (state)
      IDLE: begin
        if (draw_req) begin
          state_nxt = DRAW;
          retry_nxt = '0;
        end
      end
      DRAW: begin
        if (accept) begin
          result_nxt   = sample;
          valid_nxt    = 1'b1;
          fallback_nxt = 1'b0;
          state_nxt    = IDLE;
        end else if (retry == RETRY_MAX) begin
          result_nxt   = cnt;
          valid_nxt    = 1'b1;
          fallback_nxt = 1'b1;
          state_nxt    = IDLE;
        end else begin
          retry_nxt = retry + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == DRAW);

endmodule

// File: tb/tb_random_choice_gen.sv
// Scoreboard bench for random_choice_gen: three configurations driven in lockstep against a predictive model.
// Seed-load stimulus is exercised only when RANDOM_SEED_LOAD_EN is defined.
`timescale 1ns/1ps
module tb_random_choice_gen;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic        clk = 1'b0;
  logic        rst;
  logic        draw_req;
  logic        seed_load;
  logic [15:0] seed_in;

  logic        busy       [3];
  logic        draw_valid [3];
  logic [1:0]  com_result [3];
  logic        fallback   [3];
  logic [15:0] lfsr_dut   [3];

  always #5 clk = ~clk;

  // Instance 0: N=4 (never rejects); 1: N=3, no retries; 2: defaults N=3, 3 retries.
  random_choice_gen #(.NUM_CHOICES(4), .MAX_RETRY(3)) u_a (
    .clk(clk), .rst(rst),
`ifdef RANDOM_SEED_LOAD_EN
    .seed_load(seed_load), .seed_in(seed_in),
`endif
    .draw_req(draw_req), .busy(busy[0]), .draw_valid(draw_valid[0]),
    .com_result(com_result[0]), .fallback(fallback[0]));

  random_choice_gen #(.NUM_CHOICES(3), .MAX_RETRY(0)) u_b (
    .clk(clk), .rst(rst),
`ifdef RANDOM_SEED_LOAD_EN
    .seed_load(seed_load), .seed_in(seed_in),
`endif
    .draw_req(draw_req), .busy(busy[1]), .draw_valid(draw_valid[1]),
    .com_result(com_result[1]), .fallback(fallback[1]));

  random_choice_gen u_c (
    .clk(clk), .rst(rst),
`ifdef RANDOM_SEED_LOAD_EN
    .seed_load(seed_load), .seed_in(seed_in),
`endif
    .draw_req(draw_req), .busy(busy[2]), .draw_valid(draw_valid[2]),
    .com_result(com_result[2]), .fallback(fallback[2]));

  assign lfsr_dut[0] = u_a.lfsr;
  assign lfsr_dut[1] = u_b.lfsr;
  assign lfsr_dut[2] = u_c.lfsr;

  function automatic int n_of(input int i);
    return (i == 0) ? 4 : 3;
  endfunction

  function automatic int r_of(input int i);
    return (i == 1) ? 0 : 3;
  endfunction

  function automatic logic [15:0] nxt(input logic [15:0] x);
    if (x == 16'h0) return SEED;
    return (x >> 1) ^ (x[0] ? TAPS : 16'h0);
  endfunction

  typedef struct {
    int         inst;
    int         edge_n;
    logic [1:0] res;
    logic       fb;
  } exp_t;

  exp_t        sb [$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  bit          started = 1'b0;
  bit          rst_seen;
  logic [15:0] m_lfsr [3];
  int          m_cnt  [3];
  int          m_start[3];
  int          m_done [3];
  int          m_free [3];
  logic [1:0]  m_last [3];

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d cyc=%0d got=%0h expected=%0h", nm, i, cyc, act, exp);
    end
  endtask

  // Walk the future sample sequence from the first DRAW cycle and queue the outcome.
  task automatic predict(input int i, input logic [15:0] l_first, input int c);
    logic [15:0] s;
    exp_t e;
    s = l_first;
    for (int j = 0; j <= r_of(i); j++) begin
      if (int'(s[1:0]) < n_of(i)) begin
        e = '{inst: i, edge_n: cyc + 1 + j, res: s[1:0], fb: 1'b0};
      end else if (j == r_of(i)) begin
        e = '{inst: i, edge_n: cyc + 1 + j, res: 2'((c + 1 + j) % n_of(i)), fb: 1'b1};
      end else begin
        s = nxt(s);
        continue;
      end
      sb.push_back(e);
      m_start[i] = cyc;
      m_done[i]  = cyc + 1 + j;
      m_free[i]  = cyc + 2 + j;
      return;
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    rst_seen = !rst;
    if (!rst) started = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_lfsr[i] = SEED; m_cnt[i] = 0; m_last[i] = 2'd0;
        m_start[i] = 0; m_done[i] = 0; m_free[i] = 0;
        for (int k = sb.size() - 1; k >= 0; k--)
          if (sb[k].inst == i) sb.delete(k);
      end else begin
        logic [15:0] l_after;
        l_after = seed_load ? ((seed_in == 16'h0) ? SEED : seed_in) : nxt(m_lfsr[i]);
        if (draw_req && cyc >= m_free[i]) predict(i, l_after, m_cnt[i]);
        m_lfsr[i] = l_after;
        m_cnt[i]  = (m_cnt[i] + 1) % n_of(i);
        foreach (sb[k])
          if (sb[k].inst == i && sb[k].edge_n == cyc) m_last[i] = sb[k].res;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        logic exp_v;
        logic exp_fb;
        exp_v  = 1'b0;
        exp_fb = 1'b0;
        for (int k = sb.size() - 1; k >= 0; k--) begin
          if (sb[k].inst == i && sb[k].edge_n == cyc) begin
            exp_v  = 1'b1;
            exp_fb = sb[k].fb;
            sb.delete(k);
          end else if (sb[k].inst == i && sb[k].edge_n < cyc) begin
            chk("stale_expect", i, 32'(cyc), 32'(sb[k].edge_n));
            sb.delete(k);
          end
        end
        chk("draw_valid", i, 32'(draw_valid[i]), 32'(exp_v));
        chk("com_result", i, 32'(com_result[i]), 32'(m_last[i]));
        chk("busy", i, 32'(busy[i]), 32'(cyc >= m_start[i] && cyc < m_done[i]));
        chk("lfsr", i, 32'(lfsr_dut[i]), 32'(m_lfsr[i]));
        if (exp_v || rst_seen) chk("fallback", i, 32'(fallback[i]), 32'(exp_fb));
      end
    end
  end

  initial begin
    bit found;
    rst = 1'b0; draw_req = 1'b0; seed_load = 1'b0; seed_in = 16'h0;
    repeat (3) @(negedge clk);
    chk("reset_lfsr_seed", 2, 32'(lfsr_dut[2]), 32'(SEED));
    rst = 1'b1;

    // Single isolated request, then randomized traffic with rare resets.
    @(negedge clk); draw_req = 1'b1;
    @(negedge clk); draw_req = 1'b0;
    repeat (8) @(negedge clk);
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      draw_req = ($urandom_range(0, 9) < 7);
      rst      = ($urandom_range(0, 249) != 0);
    end
    @(negedge clk); rst = 1'b1; draw_req = 1'b0;
    repeat (8) @(negedge clk);

    // Request held high: one draw per IDLE visit.
    draw_req = 1'b1;
    repeat (10) @(negedge clk);
    draw_req = 1'b0;
    repeat (8) @(negedge clk);

    // Reset while instance 2 is mid-draw on a rejected sample.
    found = 1'b0;
    for (int k = 0; k < 500 && !found; k++) begin
      if (nxt(m_lfsr[2])[1:0] == 2'd3 && cyc >= m_free[2]) found = 1'b1;
      else @(negedge clk);
    end
    chk("force_reject_found", 2, 32'(found), 32'd1);
    draw_req = 1'b1;
    @(negedge clk); draw_req = 1'b0;
    chk("busy_before_reset", 2, 32'(busy[2]), 32'd1);
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    chk("reset_mid_draw_valid", 2, 32'(draw_valid[2]), 32'd0);
    chk("reset_mid_draw_result", 2, 32'(com_result[2]), 32'd0);
    repeat (8) @(negedge clk);

`ifdef RANDOM_SEED_LOAD_EN
    seed_load = 1'b1; seed_in = 16'h0000;
    @(negedge clk); seed_load = 1'b0;
    chk("seed_zero_load", 0, 32'(lfsr_dut[0]), 32'(SEED));
    repeat (4) @(negedge clk);
    seed_load = 1'b1; seed_in = 16'h0003; draw_req = 1'b1;
    @(negedge clk); seed_load = 1'b0; draw_req = 1'b0;
    chk("seed3_busy", 2, 32'(busy[2]), 32'd1);
    @(negedge clk);
    chk("seed3_first_rejected", 2, 32'(draw_valid[2]), 32'd0);
    chk("seed3_no_retry_fallback", 1, 32'(fallback[1]), 32'd1);
    repeat (8) @(negedge clk);
    // Random reseeding while idle, followed by draws.
    for (int k = 0; k < 20; k++) begin
      seed_load = 1'b1; seed_in = 16'($urandom); draw_req = 1'b1;
      @(negedge clk); seed_load = 1'b0; draw_req = 1'b0;
      repeat (7) @(negedge clk);
    end
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
